// File: rtl/ps2_host_tx_if.sv
// Command/status handshake and PS/2 pad signals for the host-to-device transmitter.
// master: the side that supplies commands and the raw pad levels.
// slave:  the transmitter itself.
interface ps2_host_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_err;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;

  modport master (
    output tx_valid, tx_data, ps2_clk_in, ps2_data_in,
    input  tx_ready, tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe
  );

  modport slave (
    input  tx_valid, tx_data, ps2_clk_in, ps2_data_in,
    output tx_ready, tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit the clock, request-to-send, shift one command
// byte (LSB first, odd parity, stop) on device clock falls, then check the device ACK.
// Lines are driven open-drain through the two output enables.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input logic          clk,
  input logic          rst,
  ps2_host_tx_if.slave bus
);

  localparam int unsigned InhW = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned WdW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [InhW-1:0] InhLast = InhW'(INHIBIT_CYCLES - 1);
  localparam logic [WdW-1:0]  WdLast  = WdW'(TIMEOUT_CYCLES - 1);
  localparam logic [WdW-1:0]  WdMax   = WdW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StRelease,
    StShift,
    StAck,
    StWaitIdle
  } state_e;

  state_e          state_q, state_d;
  logic [InhW-1:0] inh_q, inh_d;
  logic [WdW-1:0]  wd_q, wd_d;
  logic [3:0]      idx_q, idx_d;
  logic [9:0]      frame_q, frame_d;
  logic            data_oe_q, data_oe_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic [1:0] clk_sync_q, data_sync_q;
  logic       clk_prev_q;
  logic       clk_s, data_s, fall, timeout;
  logic       clk_oe_c, data_oe_c, ready_c;

  // Two-flop synchronizers on both pads plus one delayed copy of clk for edge detect.
  // Reset to 1 so a bus at rest never looks like a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], bus.ps2_clk_in};
      data_sync_q <= {data_sync_q[0], bus.ps2_data_in};
      clk_prev_q  <= clk_sync_q[1];
    end
  end

  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];
  assign fall   = clk_prev_q & ~clk_s;
  // Last counted cycle: the abort becomes visible TIMEOUT_CYCLES cycles after clock release.
  assign timeout = (wd_q >= WdLast);

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      inh_q     <= '0;
      wd_q      <= '0;
      idx_q     <= '0;
      frame_q   <= '0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      inh_q     <= inh_d;
      wd_q      <= wd_d;
      idx_q     <= idx_d;
      frame_q   <= frame_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic and line drive; OEs decode from state so reset releases them at once.
  always_comb begin
    state_d   = state_q;
    inh_d     = inh_q;
    wd_d      = wd_q;
    idx_d     = idx_q;
    frame_d   = frame_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    clk_oe_c  = 1'b0;
    data_oe_c = 1'b0;
    ready_c   = 1'b0;

    unique case (state_q)
      StIdle: begin
        ready_c   = 1'b1;
        inh_d     = '0;
        data_oe_d = 1'b0;
        if (bus.tx_valid) begin
          frame_d = {1'b1, ~^bus.tx_data, bus.tx_data};
          state_d = StInhibit;
        end
      end

      StInhibit: begin
        clk_oe_c = 1'b1;
        if (inh_q == InhLast) begin
          data_oe_c = 1'b1;  // start bit goes down while the clock is still held
          inh_d     = '0;
          state_d   = StRelease;
        end else begin
          inh_d = inh_q + 1'b1;
        end
      end

      StRelease: begin
        clk_oe_c  = 1'b1;
        data_oe_c = 1'b1;
        data_oe_d = 1'b1;
        wd_d      = '0;
        idx_d     = '0;
        state_d   = StShift;
      end

      StShift: begin
        data_oe_c = data_oe_q;
        wd_d      = (wd_q == WdMax) ? wd_q : wd_q + 1'b1;
        if (timeout) begin
          data_oe_d = 1'b0;
          err_d     = 1'b1;
          state_d   = StIdle;
        end else if (fall) begin
          data_oe_d = ~frame_q[idx_q];
          idx_d     = idx_q + 4'd1;
          if (idx_q == 4'd9) begin
            state_d = StAck;
          end
        end
      end

      StAck: begin
        data_oe_c = data_oe_q;
        wd_d      = (wd_q == WdMax) ? wd_q : wd_q + 1'b1;
        if (timeout) begin
          data_oe_d = 1'b0;
          err_d     = 1'b1;
          state_d   = StIdle;
        end else if (fall) begin
          if (!data_s) begin
            state_d = StWaitIdle;
          end else begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
      end

      StWaitIdle: begin
        if (clk_s && data_s) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.tx_ready    = ready_c;
  assign bus.tx_busy     = (state_q != StIdle);
  assign bus.tx_done     = done_q;
  assign bus.tx_err      = err_q;
  assign bus.ps2_clk_oe  = clk_oe_c;
  assign bus.ps2_data_oe = data_oe_c;

endmodule
